// File: rtl/led_bank_pkg.sv
// Shared definitions for the LED bank: config mode encodings, channel state type
// and a clog2 helper that never returns zero.
package led_bank_pkg;

  localparam logic [1:0] OFF   = 2'd0;
  localparam logic [1:0] ON    = 2'd1;
  localparam logic [1:0] BLINK = 2'd2;
  localparam logic [1:0] PWM   = 2'd3;

  // Channel states share the mode encoding so a config write maps straight onto a state.
  typedef enum logic [1:0] {
    ST_OFF   = OFF,
    ST_ON    = ON,
    ST_BLINK = BLINK,
    ST_PWM   = PWM
  } ch_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// Config write bus for the LED bank: the writer drives the strobe, channel, mode and
// value; the bank returns a one-cycle error pulse for out-of-range channels.
interface led_blink_bank_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16
);
  localparam int CH_W = led_bank_pkg::clog2_min1(CHANNELS);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_val;
  logic             cfg_err;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_val, input cfg_err);
  modport slave  (input cfg_we, cfg_ch, cfg_mode, cfg_val, output cfg_err);

endinterface

// File: rtl/led_channel.sv
// One LED channel: OFF / ON / BLINK (tick-timed half period) / PWM (shared counter compare).
// The LED flop is loaded from next-state values, so a write shows on the pin one edge later.
module led_channel
  import led_bank_pkg::*;
#(
  parameter int               DIV_W     = 16,
  parameter int               PWM_W     = 8,
  parameter logic [DIV_W-1:0] BOOT_HALF = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_blink,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] val,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] val_q, val_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             led_q, led_d;
  logic [DIV_W-1:0] half_m1;

  assign half_m1 = (val_q == '0) ? '0 : val_q - 1'b1;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A write takes priority over a coincident tick; that tick is simply dropped here.
    if (load) begin
      state_d = ch_state_e'(mode);
      val_d   = val;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == ST_BLINK && tick) begin
      if (cnt_q == half_m1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // pwm_cnt is the counter value of the coming cycle, keeping the compare aligned.
    led_d = 1'b0;
    case (state_d)
      ST_OFF:   led_d = 1'b0;
      ST_ON:    led_d = 1'b1;
      ST_BLINK: led_d = phase_d;
      ST_PWM:   led_d = (pwm_cnt < val_d[PWM_W-1:0]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= boot_blink ? ST_BLINK : ST_OFF;
      val_q   <= boot_blink ? BOOT_HALF : '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: shared tick prescaler, shared PWM counter, config write
// decode with out-of-range error pulse, and one led_channel per output.
module led_blink_bank
  import led_bank_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int CHANNELS   = 4,
  parameter int DIV_W      = 16,
  parameter int PWM_W      = 8,
  parameter int BOOT_BLINK = 1
) (
  input  logic                clk,
  input  logic                rst,
  led_blink_bank_if.slave     cfg,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int               P_DIV     = CLK_FREQ / TICK_HZ;
  localparam int               P         = (P_DIV < 1) ? 1 : P_DIV;
  localparam int               PCNT_W    = clog2_min1(P);
  localparam logic [PCNT_W-1:0] P_LAST   = PCNT_W'(P - 1);
  localparam int               BOOT_HZ2  = TICK_HZ / 2;
  localparam logic [DIV_W-1:0] BOOT_HALF = DIV_W'((BOOT_HZ2 < 1) ? 1 : BOOT_HZ2);

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                tick_q, tick_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CHANNELS-1:0] load;

  always_comb begin
    pcnt_d    = (pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
    // tick is registered off the next count so it is high exactly while pcnt_q == P-1.
    tick_d    = (pcnt_d == P_LAST);
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    cfg_err_d = cfg.cfg_we && (int'(cfg.cfg_ch) >= CHANNELS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick        = tick_q;
  assign cfg.cfg_err = cfg_err_q;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign load[gi] = cfg.cfg_we && (int'(cfg.cfg_ch) == gi);

      led_channel #(
        .DIV_W     (DIV_W),
        .PWM_W     (PWM_W),
        .BOOT_HALF (BOOT_HALF)
      ) u_channel (
        .clk        (clk),
        .rst        (rst),
        .boot_blink ((BOOT_BLINK != 0) && (gi == 0)),
        .load       (load[gi]),
        .mode       (cfg.cfg_mode),
        .val        (cfg.cfg_val),
        .tick       (tick_q),
        .pwm_cnt    (pwm_cnt_d),
        .led        (led[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank: P=10 clocks per tick, 4 channels, 8-bit PWM,
// plus a 3-channel instance to exercise the out-of-range write error.
module tb_led_blink_bank;
  import led_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick, tick3;
  logic [3:0] led;
  logic [2:0] led3;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  led_blink_bank_if #(.CHANNELS(4), .DIV_W(16)) bus ();
  led_blink_bank_if #(.CHANNELS(3), .DIV_W(16)) bus3 ();

  led_blink_bank #(
    .CLK_FREQ(1000), .TICK_HZ(100), .CHANNELS(4), .DIV_W(16), .PWM_W(8), .BOOT_BLINK(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg(bus), .tick(tick), .led(led)
  );

  led_blink_bank #(
    .CLK_FREQ(1000), .TICK_HZ(100), .CHANNELS(3), .DIV_W(16), .PWM_W(8), .BOOT_BLINK(1)
  ) dut3 (
    .clk(clk), .rst(rst), .cfg(bus3), .tick(tick3), .led(led3)
  );

  // Cycle index since reset release: 0 is the reset-state cycle, n after n edges.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] mode, input int val);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = 2'(ch);
    bus.cfg_mode = mode;
    bus.cfg_val  = 16'(val);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bus.cfg_we = 1'b0;  bus.cfg_ch = '0;  bus.cfg_mode = OFF;  bus.cfg_val = '0;
    bus3.cfg_we = 1'b0; bus3.cfg_ch = '0; bus3.cfg_mode = OFF; bus3.cfg_val = '0;

    // Reset held for 4 clocks
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_err", 32'(bus.cfg_err), 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 30; c++) begin
      wait_cyc(c);
      chk("tick", 32'(tick), 32'(c % 10 == 9));
    end
    chk("tick3", 32'(tick3), 32'd1);

    // ch1 BLINK half=3 ticks, written on a non-tick cycle
    wait_cyc(40);
    cfg_write(1, BLINK, 3);
    chk("b3_dark41", 32'(led[1]), 32'd0);
    wait_cyc(69);  chk("b3_dark69", 32'(led[1]), 32'd0);
    wait_cyc(70);  chk("b3_rise70", 32'(led[1]), 32'd1);
    wait_cyc(99);  chk("b3_hi99", 32'(led[1]), 32'd1);
    wait_cyc(100); chk("b3_fall100", 32'(led[1]), 32'd0);

    // ch2 PWM duty 64: high for pwm_cnt 0..63 of each 256-cycle period
    wait_cyc(110);
    cfg_write(2, PWM, 64);
    hi = 0;
    for (int c = 112; c <= 367; c++) begin
      wait_cyc(c);
      if (led[2]) hi++;
    end
    chk("pwm64_count", 32'(hi), 32'd64);

    // ch3 ON then OFF back to back
    wait_cyc(380);
    chk("on_pre", 32'(led[3]), 32'd0);
    cfg_write(3, ON, 0);
    chk("on_pulse", 32'(led[3]), 32'd1);
    cfg_write(3, OFF, 0);
    chk("off_after", 32'(led[3]), 32'd0);

    // Out-of-range channel on the 3-channel instance
    wait_cyc(390);
    bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_mode = ON; bus3.cfg_val = 16'd5;
    @(negedge clk);
    bus3.cfg_we = 1'b0;
    chk("err3_pulse", 32'(bus3.cfg_err), 32'd1);
    chk("err_main", 32'(bus.cfg_err), 32'd0);
    chk("err3_led", 32'(led3), 32'd0);
    @(negedge clk);
    chk("err3_clear", 32'(bus3.cfg_err), 32'd0);
    chk("err3_led2", 32'(led3), 32'd0);

    // Boot blink on ch0: first rise 500 cycles after release
    wait_cyc(499); chk("boot_dark499", 32'(led[0]), 32'd0);
    wait_cyc(500); chk("boot_rise500", 32'(led[0]), 32'd1);
    chk("boot3_rise500", 32'(led3), 32'd1);
    chk("pwm64_low500", 32'(led[2]), 32'd0);
    wait_cyc(575); chk("pwm64_hi575", 32'(led[2]), 32'd1);
    wait_cyc(576); chk("pwm64_lo576", 32'(led[2]), 32'd0);

    // ch1 rewritten on a tick cycle with val=0 (acts as half=1): restart wins over the tick
    wait_cyc(589);
    chk("tick589", 32'(tick), 32'd1);
    cfg_write(1, BLINK, 0);
    chk("wr_tick590", 32'(led[1]), 32'd0);
    wait_cyc(599); chk("v0_dark599", 32'(led[1]), 32'd0);
    wait_cyc(600); chk("v0_rise600", 32'(led[1]), 32'd1);
    wait_cyc(609); chk("v0_hi609", 32'(led[1]), 32'd1);
    wait_cyc(610); chk("v0_fall610", 32'(led[1]), 32'd0);

    // PWM duty 0 never lights
    wait_cyc(620);
    cfg_write(2, PWM, 0);
    hi = 0;
    for (int c = 622; c <= 877; c++) begin
      wait_cyc(c);
      if (led[2]) hi++;
    end
    chk("pwm0_count", 32'(hi), 32'd0);

    wait_cyc(999);  chk("boot_hi999", 32'(led[0]), 32'd1);
    wait_cyc(1000); chk("boot_fall1000", 32'(led[0]), 32'd0);

    // PWM duty 255: dark only where pwm_cnt == 255
    wait_cyc(1010);
    cfg_write(2, PWM, 255);
    hi = 0;
    for (int c = 1012; c <= 1267; c++) begin
      wait_cyc(c);
      if (led[2]) hi++;
      if (c == 1023) chk("pwm255_low1023", 32'(led[2]), 32'd0);
    end
    chk("pwm255_count", 32'(hi), 32'd255);

    // One-cycle reset mid-operation
    wait_cyc(1300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_led", 32'(led), 32'd0);
    chk("rst2_tick", 32'(tick), 32'd0);
    chk("rst2_err", 32'(bus.cfg_err), 32'd0);
    wait_cyc(1);   chk("rst2_led1", 32'(led), 32'd0);
    wait_cyc(8);   chk("rst2_tick8", 32'(tick), 32'd0);
    wait_cyc(9);   chk("rst2_tick9", 32'(tick), 32'd1);
    wait_cyc(499); chk("rst2_led499", 32'(led), 32'd0);
    wait_cyc(500); chk("rst2_led500", 32'(led), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
